// File: rtl/pulsegen_pkg.sv
// Shared state encoding for the multi-channel step-counted pulse generator.
package pulsegen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } state_e;

endpackage

// File: rtl/pulsegen_chan.sv
// One pulse channel: trigger edge detect, IDLE/DELAY/PULSE FSM and step counter.
// Outputs are registered one cycle behind the state register; no backpressure.
module pulsegen_chan
  import pulsegen_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             step_rise_i,
  input  logic             trigger_i,
  input  logic             abort_i,
  input  logic             repeat_en_i,
  input  logic [WIDTH-1:0] delay_i,
  input  logic [WIDTH-1:0] width_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             trig_q;
  logic             evt_q, evt_d;
  logic             pulse_q, busy_q, done_q;

  logic             trig_rise;
  logic [WIDTH:0]   dec_w;
  state_e           eop_state;
  logic [WIDTH-1:0] eop_count;
  logic             eop_done;

  assign trig_rise = trigger_i & ~trig_q;
  assign dec_w     = {1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1};

  // End of a pulse: finish, or reload the next period from the live presets.
  always_comb begin
    eop_state = IDLE;
    eop_count = '0;
    eop_done  = 1'b1;
    if (repeat_en_i) begin
      if (delay_i != '0) begin
        eop_state = DELAY;
        eop_count = delay_i;
        eop_done  = 1'b0;
      end else if (width_i != '0) begin
        eop_state = PULSE;
        eop_count = width_i;
        eop_done  = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    evt_d   = 1'b0;
    if (abort_i || !enable_i) begin
      state_d = IDLE;
      count_d = '0;
    end else if (trig_rise) begin
      if (delay_i != '0) begin
        state_d = DELAY;
        count_d = delay_i;
      end else if (width_i != '0) begin
        state_d = PULSE;
        count_d = width_i;
      end else begin
        state_d = IDLE;
        count_d = '0;
        evt_d   = 1'b1;
      end
    end else if (step_rise_i) begin
      unique case (state_q)
        DELAY: begin
          if (count_q > CNT_ONE) begin
            count_d = dec_w[WIDTH-1:0];
          end else if (count_q == CNT_ONE) begin
            if (width_i != '0) begin
              state_d = PULSE;
              count_d = width_i;
            end else begin
              state_d = eop_state;
              count_d = eop_count;
              evt_d   = eop_done;
            end
          end
        end
        PULSE: begin
          if (count_q > CNT_ONE) begin
            count_d = dec_w[WIDTH-1:0];
          end else if (count_q == CNT_ONE) begin
            state_d = eop_state;
            count_d = eop_count;
            evt_d   = eop_done;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      count_q <= '0;
      trig_q  <= 1'b0;
      evt_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      trig_q  <= trigger_i;
      evt_q   <= evt_d;
      pulse_q <= (state_q == PULSE);
      busy_q  <= (state_q != IDLE);
      done_q  <= evt_q;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/pulsegen_multi.sv
// CHANNELS independent step-timed pulse generators sharing one step strobe and enable.
// State moves on the trigger-rise edge; busy/pulse follow one cycle later; no backpressure.
module pulsegen_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                      sysclk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      step,
  input  logic [CHANNELS-1:0]       trigger,
  input  logic [CHANNELS-1:0]       abort,
  input  logic [CHANNELS-1:0]       repeat_en,
  input  logic [CHANNELS*WIDTH-1:0] delay_preset,
  input  logic [CHANNELS*WIDTH-1:0] width_preset,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);

  logic step_q;
  logic step_rise;

  assign step_rise = step & ~step_q;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    pulsegen_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk_i       (sysclk),
      .rst_n_i     (rst_n),
      .enable_i    (enable),
      .step_rise_i (step_rise),
      .trigger_i   (trigger[c]),
      .abort_i     (abort[c]),
      .repeat_en_i (repeat_en[c]),
      .delay_i     (delay_preset[c*WIDTH +: WIDTH]),
      .width_i     (width_preset[c*WIDTH +: WIDTH]),
      .pulse_o     (pulse[c]),
      .busy_o      (busy[c]),
      .done_o      (done[c])
    );
  end

endmodule

// File: tb/tb_pulsegen_multi.sv
// Directed bench for pulsegen_multi; WIDTH is narrowed so the all-ones delay run stays short.
module tb_pulsegen_multi;

  localparam int CH = 4;
  localparam int W  = 12;

  logic            sysclk;
  logic            rst_n;
  logic            enable;
  logic            step;
  logic [CH-1:0]   trigger;
  logic [CH-1:0]   abort;
  logic [CH-1:0]   repeat_en;
  logic [CH*W-1:0] delay_preset;
  logic [CH*W-1:0] width_preset;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   done;

  int checks   = 0;
  int failures = 0;

  pulsegen_multi #(
    .CHANNELS(CH),
    .WIDTH   (W)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .enable      (enable),
    .step        (step),
    .trigger     (trigger),
    .abort       (abort),
    .repeat_en   (repeat_en),
    .delay_preset(delay_preset),
    .width_preset(width_preset),
    .pulse       (pulse),
    .busy        (busy),
    .done        (done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_preset(input int c, input logic [W-1:0] d, input logic [W-1:0] w);
    delay_preset[c*W +: W] = d;
    width_preset[c*W +: W] = w;
  endtask

  // One trigger rise sampled at the next edge; returns just after that edge.
  task automatic trig(input logic [CH-1:0] m);
    trigger = m;
    tick();
    trigger = '0;
  endtask

  // One step rise; returns just after the following edge so outputs show its effect.
  task automatic stp();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b1;
    step         = 1'b0;
    trigger      = '1;
    abort        = '0;
    repeat_en    = '0;
    delay_preset = '0;
    width_preset = '0;
    for (int c = 0; c < CH; c++) set_preset(c, W'(5), W'(5));

    // Reset dominates trigger and step activity
    for (int i = 0; i < 4; i++) begin
      step = ~step;
      tick();
    end
    chk("rst_pulse", 32'(pulse), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_done",  32'(done),  32'h0);
    step  = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rel_busy_n",  32'(busy), 32'h0);
    tick();
    chk("rel_busy_n1", 32'(busy), 32'hF);
    abort = '1;
    tick();
    abort   = '0;
    trigger = '0;
    tick();
    chk("abort_all_busy", 32'(busy), 32'h0);

    // One-shot ch0: delay=2 width=3
    set_preset(0, W'(2), W'(3));
    trig(4'b0001);
    chk("os_busy_n", 32'(busy), 32'h0);
    tick();
    chk("os_busy_n1",  32'(busy),  32'h1);
    chk("os_pulse_n1", 32'(pulse), 32'h0);
    stp();
    chk("os_pulse_s1", 32'(pulse), 32'h0);
    stp();
    chk("os_pulse_s2", 32'(pulse), 32'h1);
    stp();
    stp();
    chk("os_pulse_s4", 32'(pulse), 32'h1);
    step = 1'b1;
    tick();
    chk("os_pulse_s5e", 32'(pulse), 32'h1);
    chk("os_done_s5e",  32'(done),  32'h0);
    step = 1'b0;
    tick();
    chk("os_pulse_end", 32'(pulse), 32'h0);
    chk("os_busy_end",  32'(busy),  32'h0);
    chk("os_done_end",  32'(done),  32'h1);
    tick();
    chk("os_done_1cyc", 32'(done), 32'h0);

    // delay=0 width=1, then delay=0 width=0
    set_preset(0, W'(0), W'(1));
    trig(4'b0001);
    chk("d0w1_pulse_n", 32'(pulse), 32'h0);
    tick();
    chk("d0w1_pulse_n1", 32'(pulse), 32'h1);
    stp();
    chk("d0w1_pulse_off", 32'(pulse), 32'h0);
    chk("d0w1_done",      32'(done),  32'h1);
    set_preset(0, W'(0), W'(0));
    tick();
    trig(4'b0001);
    chk("d0w0_done_n", 32'(done), 32'h0);
    tick();
    chk("d0w0_done_n1",  32'(done),  32'h1);
    chk("d0w0_busy_n1",  32'(busy),  32'h0);
    chk("d0w0_pulse_n1", 32'(pulse), 32'h0);
    tick();
    chk("d0w0_done_n2", 32'(done), 32'h0);

    // Periodic ch1: delay=1 width=2 -> 0,1,1 per period, never done
    set_preset(1, W'(1), W'(2));
    repeat_en = 4'b0010;
    trig(4'b0010);
    tick();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("per_pulse_%0d", i), 32'(pulse[1]), (i % 3 == 0) ? 32'h0 : 32'h1);
      stp();
      chk($sformatf("per_done_%0d", i), 32'(done), 32'h0);
    end
    stp();
    chk("per_pulse_pre_abort", 32'(pulse), 32'h2);
    abort = 4'b0010;
    tick();
    abort = '0;
    tick();
    chk("abort_pulse", 32'(pulse), 32'h0);
    chk("abort_busy",  32'(busy),  32'h0);
    chk("abort_done",  32'(done),  32'h0);
    tick();
    chk("abort_done_n2", 32'(done), 32'h0);
    repeat_en = '0;

    // Retrigger beats a terminal step in PULSE; retrigger mid-DELAY restarts
    set_preset(2, W'(1), W'(1));
    trig(4'b0100);
    tick();
    stp();
    chk("rt_pulse_in", 32'(pulse), 32'h4);
    set_preset(2, W'(3), W'(2));
    trigger = 4'b0100;
    step    = 1'b1;
    tick();
    trigger = '0;
    step    = 1'b0;
    tick();
    chk("rt_pulse", 32'(pulse), 32'h0);
    chk("rt_busy",  32'(busy),  32'h4);
    chk("rt_done",  32'(done),  32'h0);
    tick();
    chk("rt_done_n2", 32'(done), 32'h0);
    stp();
    set_preset(2, W'(5), W'(2));
    trig(4'b0100);
    tick();
    for (int i = 0; i < 4; i++) stp();
    chk("rt5_pulse_s4", 32'(pulse), 32'h0);
    chk("rt5_busy_s4",  32'(busy),  32'h4);
    stp();
    chk("rt5_pulse_s5", 32'(pulse), 32'h4);
    abort = 4'b0100;
    tick();
    abort = '0;
    tick();

    // Global enable drop clears every channel
    for (int c = 0; c < CH; c++) set_preset(c, W'(0), W'(10));
    trig(4'hF);
    tick();
    chk("en_pulse_pre", 32'(pulse), 32'hF);
    chk("en_busy_pre",  32'(busy),  32'hF);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    chk("en_pulse_post", 32'(pulse), 32'h0);
    chk("en_busy_post",  32'(busy),  32'h0);
    chk("en_done_post",  32'(done),  32'h0);

    // All-ones delay on ch3: leaves DELAY on exactly the 2^W-1 th step
    set_preset(3, '1, W'(1));
    trig(4'b1000);
    tick();
    for (int i = 0; i < (1 << W) - 2; i++) stp();
    chk("max_pulse_pre", 32'(pulse), 32'h0);
    chk("max_busy_pre",  32'(busy),  32'h8);
    stp();
    chk("max_pulse_hit", 32'(pulse), 32'h8);
    stp();
    chk("max_pulse_end", 32'(pulse), 32'h0);
    chk("max_done_end",  32'(done),  32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
